// File: rtl/coreuart_rx_fifo.sv
// ---------------------------------------------------------------------------
// coreuart_rx_fifo
// Receive FIFO sitting directly behind the UART receiver. Each received byte
// is stored with its parity-error flag on the receiver's one-cycle write
// strobe. Entries are held until the register interface pops the RX data
// register. The head entry is presented first-word-fall-through.
//
// Ports
//   CLK       in   system clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   clr       in   synchronous flush (pointers, count and overflow to zero)
//   wr_en     in   one-cycle write strobe (byte complete)
//   wr_data   in   received byte
//   wr_perr   in   parity error for this byte
//   rd_en     in   one-cycle pop strobe
//   clr_ovf   in   clears the sticky overflow flag
//   rd_data   out  head-of-queue byte (valid while empty=0)
//   rd_perr   out  parity flag stored with the head byte
//   empty     out  no entries
//   full      out  count == DEPTH
//   afull     out  count >= AFULL_LVL
//   count     out  occupancy 0..DEPTH
//   overflow  out  sticky: a write was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module coreuart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          wr_perr,
    input  logic          rd_en,
    input  logic          clr_ovf,
    output logic [7:0]    rd_data,
    output logic          rd_perr,
    output logic          empty,
    output logic          full,
    output logic          afull,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_AFULL = (AW+1)'(AFULL_LVL);

    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic          w_empty;
    logic          w_full;
    logic          w_do_wr;
    logic          w_do_rd;
    logic          w_drop;
    logic [AW:0]   w_count_nxt;

    // Occupancy decode and accept/drop decisions from registered state.
    always_comb begin
        w_empty = (r_count == {(AW+1){1'b0}});
        w_full  = (r_count == LP_DEPTH);
        // A read is only honoured when something is stored.
        w_do_rd = rd_en & ~w_empty;
        // When full, a simultaneous pop frees the slot the write lands in.
        w_do_wr = wr_en & (~w_full | rd_en);
        w_drop  = wr_en & w_full & ~rd_en;
    end

    // Next occupancy: unchanged when push and pop coincide.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_wr, w_do_rd})
            2'b10:   w_count_nxt = r_count + {{AW{1'b0}}, 1'b1};
            2'b01:   w_count_nxt = r_count - {{AW{1'b0}}, 1'b1};
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer, count and sticky overflow state; flush dominates everything.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wp       <= {AW{1'b0}};
            r_rp       <= {AW{1'b0}};
            r_count    <= {(AW+1){1'b0}};
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_wp       <= {AW{1'b0}};
            r_rp       <= {AW{1'b0}};
            r_count    <= {(AW+1){1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_wp <= r_wp + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                r_wp <= r_wp;
            end
            if (w_do_rd) begin
                r_rp <= r_rp + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                r_rp <= r_rp;
            end
            r_count <= w_count_nxt;
            // A dropped write outranks a same-cycle clear request.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge CLK) begin
        if (w_do_wr && !clr) begin
            r_mem[r_wp] <= {wr_perr, wr_data};
        end
    end

    // Head entry falls through; status comes only from the registered count.
    always_comb begin
        rd_data  = r_mem[r_rp][7:0];
        rd_perr  = r_mem[r_rp][8];
        empty    = (r_count == {(AW+1){1'b0}});
        full     = (r_count == LP_DEPTH);
        afull    = (r_count >= LP_AFULL);
        count    = r_count;
        overflow = r_overflow;
    end

endmodule
